// File: rtl/door_pkg.sv
// Shared types and default constants for the door actuator.
package door_pkg;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        OPENING = 3'd1,
        OPEN    = 3'd2,
        CLOSING = 3'd3,
        FAULT   = 3'd4
    } door_state_e;

    localparam int unsigned DOOR_TIMEOUT_DEF  = 1000;
    localparam int unsigned DOOR_DEBOUNCE_DEF = 4;

    function automatic logic is_moving(door_state_e s);
        return (s == OPENING) || (s == CLOSING);
    endfunction

endpackage

// File: rtl/door_actuator_if.sv
// Door command / sensor / motor bundle between controller side and actuator.
// The obstruction line exists only when DOOR_OBSTRUCT_REVERSE_EN is defined.
interface door_actuator_if;
    import door_pkg::*;

    logic        door_open;
    logic        limit_open;
    logic        limit_closed;
    logic        fault_clr;
`ifdef DOOR_OBSTRUCT_REVERSE_EN
    logic        obstruction;
`endif
    logic        motor_open;
    logic        motor_close;
    door_state_e door_state;
    logic        fault;

`ifdef DOOR_OBSTRUCT_REVERSE_EN
    modport master (
        output door_open, limit_open, limit_closed, fault_clr, obstruction,
        input  motor_open, motor_close, door_state, fault
    );
    modport slave (
        input  door_open, limit_open, limit_closed, fault_clr, obstruction,
        output motor_open, motor_close, door_state, fault
    );
`else
    modport master (
        output door_open, limit_open, limit_closed, fault_clr,
        input  motor_open, motor_close, door_state, fault
    );
    modport slave (
        input  door_open, limit_open, limit_closed, fault_clr,
        output motor_open, motor_close, door_state, fault
    );
`endif

endinterface

// File: rtl/door_debounce.sv
// Two-flop synchroniser followed by a stable-sample counter for one raw sensor input.
module door_debounce import door_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES = DOOR_DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_db
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive synchronised samples that disagree with r_db.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/door_actuator.sv
// Door actuator: debounced limit switches, door FSM with timeout, registered motor outputs.
// Define DOOR_OBSTRUCT_REVERSE_EN to add obstruction sensing with reversal while closing.
module door_actuator import door_pkg::*; #(
    parameter int unsigned TIMEOUT_CYCLES  = DOOR_TIMEOUT_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DOOR_DEBOUNCE_DEF
) (
    input logic            clk,
    input logic            rst_n,
    door_actuator_if.slave io_bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    logic          w_lim_open_db;
    logic          w_lim_closed_db;
    logic          w_obs_db;
    logic          w_tmo_hit;
    door_state_e   w_state_next;

    door_state_e   r_state;
    logic          r_motor_open;
    logic          r_motor_close;
    logic          r_fault;
    logic [TW-1:0] r_tmo;

    door_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_open (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (io_bus.limit_open),
        .o_db  (w_lim_open_db)
    );

    door_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_closed (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (io_bus.limit_closed),
        .o_db  (w_lim_closed_db)
    );

`ifdef DOOR_OBSTRUCT_REVERSE_EN
    door_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_obs (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (io_bus.obstruction),
        .o_db  (w_obs_db)
    );
`else
    assign w_obs_db = 1'b0;
`endif

    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_next = r_state;
        if (r_state != FAULT && w_lim_open_db && w_lim_closed_db) begin
            w_state_next = FAULT;
        end else begin
            case (r_state)
                CLOSED: begin
                    if (io_bus.door_open) w_state_next = OPENING;
                end
                OPENING: begin
                    if (w_lim_open_db)                       w_state_next = OPEN;
                    else if (!io_bus.door_open && !w_obs_db) w_state_next = CLOSING;
                    else if (w_tmo_hit)                      w_state_next = FAULT;
                end
                OPEN: begin
                    if (!io_bus.door_open && !w_obs_db) w_state_next = CLOSING;
                end
                CLOSING: begin
                    if (w_obs_db)              w_state_next = OPENING;
                    else if (w_lim_closed_db)  w_state_next = CLOSED;
                    else if (io_bus.door_open) w_state_next = OPENING;
                    else if (w_tmo_hit)        w_state_next = FAULT;
                end
                FAULT: begin
                    if (io_bus.fault_clr) begin
                        if (w_lim_closed_db)    w_state_next = CLOSED;
                        else if (w_lim_open_db) w_state_next = OPEN;
                        else                    w_state_next = CLOSING;
                    end
                end
                default: w_state_next = FAULT;
            endcase
        end
    end

    // Outputs decode the next state so they line up with door_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= CLOSED;
            r_motor_open  <= 1'b0;
            r_motor_close <= 1'b0;
            r_fault       <= 1'b0;
            r_tmo         <= '0;
        end else begin
            r_state       <= w_state_next;
            r_motor_open  <= (w_state_next == OPENING);
            r_motor_close <= (w_state_next == CLOSING);
            r_fault       <= (w_state_next == FAULT);
            if (w_state_next != r_state) begin
                r_tmo <= '0;
            end else if (is_moving(r_state) && (r_tmo != '1)) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign io_bus.motor_open  = r_motor_open;
    assign io_bus.motor_close = r_motor_close;
    assign io_bus.door_state  = r_state;
    assign io_bus.fault       = r_fault;

endmodule

// File: tb/tb_door_actuator.sv
// Self-checking bench for door_actuator: per-cycle model comparison plus directed literal checks.
module tb_door_actuator;
    import door_pkg::*;

    localparam int T       = 20;
    localparam int DEB     = 2;
    localparam int TMO_MAX = (1 << $clog2(T)) - 1;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic obs_raw = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    door_actuator_if bus();

    door_actuator #(.TIMEOUT_CYCLES(T), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

`ifdef DOOR_OBSTRUCT_REVERSE_EN
    assign bus.obstruction = obs_raw;
`endif

    always #5 clk = ~clk;

    // Model: sensor history of raw samples, door rules applied on debounced views.
    int           m_st  = 0;
    int           m_tmo = 0;
    int           m_nxt = 0;
    bit [DEB+1:0] h_lo  = '0;
    bit [DEB+1:0] h_lc  = '0;
    bit [DEB+1:0] h_ob  = '0;
    bit           m_lo  = 1'b0;
    bit           m_lc  = 1'b0;
    bit           m_ob  = 1'b0;

    // Debounced view flips once the DEB samples seen through the synchroniser all agree.
    function automatic bit settle(bit [DEB+1:0] h, bit cur);
        bit [DEB-1:0] w;
        w = h[DEB+1:2];
        if (&w)  return 1'b1;
        if (~|w) return 1'b0;
        return cur;
    endfunction

    function automatic int fsm_next(int s, bit dopen, bit clr, bit lo, bit lc, bit ob, int tmo);
        bit hit;
        hit = (tmo == T - 1);
        if (s != 4 && lo && lc) return 4;
        case (s)
            0: return dopen ? 1 : 0;
            1: begin
                if (lo)              return 2;
                if (!dopen && !ob)   return 3;
                if (hit)             return 4;
                return 1;
            end
            2: return (!dopen && !ob) ? 3 : 2;
            3: begin
                if (ob)    return 1;
                if (lc)    return 0;
                if (dopen) return 1;
                if (hit)   return 4;
                return 3;
            end
            default: begin
                if (!clr) return 4;
                if (lc)   return 0;
                if (lo)   return 2;
                return 3;
            end
        endcase
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_st = 0; m_tmo = 0;
            h_lo = '0; h_lc = '0; h_ob = '0;
            m_lo = 1'b0; m_lc = 1'b0; m_ob = 1'b0;
        end else begin
            m_nxt = fsm_next(m_st, bus.door_open, bus.fault_clr, m_lo, m_lc, m_ob, m_tmo);
            if (m_nxt != m_st) m_tmo = 0;
            else if ((m_st == 1 || m_st == 3) && m_tmo < TMO_MAX) m_tmo = m_tmo + 1;
            m_st = m_nxt;
            h_lo = {h_lo[DEB:0], bus.limit_open};
            h_lc = {h_lc[DEB:0], bus.limit_closed};
            h_ob = {h_ob[DEB:0], obs_raw};
            m_lo = settle(h_lo, m_lo);
            m_lc = settle(h_lc, m_lc);
            m_ob = settle(h_ob, m_ob);
        end
    end

    initial forever begin
        @(negedge clk);
        n_checks++;
        if (bus.door_state !== 3'(m_st) || bus.motor_open !== (m_st == 1) ||
            bus.motor_close !== (m_st == 3) || bus.fault !== (m_st == 4) ||
            (bus.motor_open === 1'b1 && bus.motor_close === 1'b1)) begin
            n_errors++;
            $display("FAIL cycle_model t=%0t got state=%0d mo=%b mc=%b f=%b want state=%0d mo=%b mc=%b f=%b",
                     $time, bus.door_state, bus.motor_open, bus.motor_close, bus.fault,
                     m_st, (m_st == 1), (m_st == 3), (m_st == 4));
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Counts clocks until door_state reaches exp_state (bounded), then checks the count.
    task automatic wait_state(input string name, input int exp_state, input int exp_cycles);
        int n;
        n = 0;
        while (int'(bus.door_state) != exp_state && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        #1;
        check(name, n, exp_cycles);
    endtask

    initial begin
        bus.door_open    = 1'b0;
        bus.limit_open   = 1'b0;
        bus.limit_closed = 1'b0;
        bus.fault_clr    = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("reset_state", int'(bus.door_state), 0);
        check("reset_motors", int'({bus.motor_open, bus.motor_close}), 0);
        check("reset_fault", int'(bus.fault), 0);

        // Open with limit switch
        bus.door_open = 1'b1;
        wait_state("open_cmd_lat", 1, 1);
        check("open_motor_on", int'(bus.motor_open), 1);
        tick(3);
        bus.limit_open = 1'b1;
        wait_state("open_limit_lat", 2, 5);
        check("open_motor_off", int'({bus.motor_open, bus.motor_close}), 0);

        // Close with limit switch
        bus.door_open  = 1'b0;
        bus.limit_open = 1'b0;
        wait_state("close_cmd_lat", 3, 1);
        check("close_motor_on", int'(bus.motor_close), 1);
        tick(4);
        bus.limit_closed = 1'b1;
        wait_state("close_limit_lat", 0, 5);
        check("closed_motors_off", int'({bus.motor_open, bus.motor_close}), 0);

        // Timeout while opening, then clear with no limits
        bus.limit_closed = 1'b0;
        tick(6);
        bus.door_open = 1'b1;
        wait_state("tmo_enter_opening", 1, 1);
        wait_state("tmo_latency", 4, 20);
        check("tmo_fault_flag", int'(bus.fault), 1);
        check("tmo_motors_off", int'({bus.motor_open, bus.motor_close}), 0);
        bus.door_open = 1'b0;
        tick(2);
        check("fault_ignores_cmd", int'(bus.door_state), 4);
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        check("clr_to_closing", int'(bus.door_state), 3);
        check("clr_fault_low", int'(bus.fault), 0);
        bus.limit_closed = 1'b1;
        wait_state("clr_close_limit", 0, 5);

        // Direct reversal and limit glitches
        bus.limit_closed = 1'b0;
        tick(6);
        bus.door_open = 1'b1;
        wait_state("rev_opening", 1, 1);
        tick(2);
        bus.door_open = 1'b0;
        wait_state("rev_to_closing", 3, 1);
        check("rev_motors", int'({bus.motor_open, bus.motor_close}), 1);
        bus.door_open = 1'b1;
        wait_state("rev_back_opening", 1, 1);
        for (int i = 0; i < 3; i++) begin
            bus.limit_open = 1'b1;
            tick(1);
            bus.limit_open = 1'b0;
            tick(2);
        end
        check("glitch_ignored", int'(bus.door_state), 1);
        bus.limit_open = 1'b1;
        wait_state("glitch_then_open", 2, 5);

        // Both limits in OPEN
        bus.limit_closed = 1'b1;
        wait_state("both_limits_fault", 4, 5);
        check("both_limits_flag", int'(bus.fault), 1);
        bus.limit_open = 1'b0;
        tick(6);
        bus.door_open = 1'b0;
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        check("clr_to_closed", int'(bus.door_state), 0);

        // Reset mid-closing
        bus.limit_closed = 1'b0;
        tick(6);
        bus.door_open = 1'b1;
        wait_state("rst_opening", 1, 1);
        bus.limit_open = 1'b1;
        wait_state("rst_open", 2, 5);
        bus.limit_open = 1'b0;
        bus.door_open  = 1'b0;
        wait_state("rst_closing", 3, 1);
        tick(2);
        check("rst_pre_motor", int'(bus.motor_close), 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_motors", int'({bus.motor_open, bus.motor_close}), 0);
        check("rst_async_state", int'(bus.door_state), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("rst_release_state", int'(bus.door_state), 0);

`ifdef DOOR_OBSTRUCT_REVERSE_EN
        // Obstruction reverses a closing door
        bus.door_open = 1'b1;
        wait_state("obs_opening", 1, 1);
        bus.limit_open = 1'b1;
        wait_state("obs_open", 2, 5);
        bus.limit_open = 1'b0;
        bus.door_open  = 1'b0;
        wait_state("obs_closing", 3, 1);
        tick(3);
        obs_raw = 1'b1;
        tick(4);
        obs_raw = 1'b0;
        wait_state("obs_reverse", 1, 1);
        check("obs_motor_open", int'(bus.motor_open), 1);
        wait_state("obs_release", 3, 4);
`endif

        tick(3);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
